reg_scoreboard: RTL

Register-write scoreboard for the in-order pipeline, running in the opposite direction to the ID→ALU pipeline register. It tracks, per architectural register, how many issued instructions still owe a write. It raises a stall back to ID when a source operand or the destination counter is not ready. Issue events come from ID; retire events (writeback, and kill on flush) come back from the later stages.

---
 rtl/reg_scoreboard.sv | 59 +++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters producing the ID-stage RAW/full stall
module reg_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2,
  parameter int TOT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              rs1_use,
  input  logic              rs2_use,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              kill_valid,
  input  logic [ADDR_W-1:0] kill_rd,
  output logic              id_stall,
  output logic              iss_fire,
  output logic [TOT_W-1:0]  inflight,
  output logic              sb_err
);
  logic [CNT_W-1:0] cnt [REG_NUM];
  logic [REG_NUM-1:0] under;
  logic raw1, raw2, full, iss_hit, wb_hit, kill_hit, t_under;
  logic [1:0] t_dec;
  logic [TOT_W:0] t_sum, t_next;
  assign raw1 = rs1_use && rs1_addr != '0 && cnt[rs1_addr] != '0;
  assign raw2 = rs2_use && rs2_addr != '0 && cnt[rs2_addr] != '0;
  assign full = iss_we && iss_rd != '0 && cnt[iss_rd] == '1;
  assign id_stall = iss_valid && (raw1 || raw2 || full);
  assign iss_fire = iss_valid && !id_stall;
  assign iss_hit = iss_fire && iss_we && iss_rd != '0;
  assign wb_hit = wb_valid && wb_rd != '0;
  assign kill_hit = kill_valid && kill_rd != '0;
  genvar r;
  for (r = 0; r < REG_NUM; r++) begin : g_reg
    logic inc;
    logic [1:0] dec;
    logic [CNT_W:0] sum;
    assign inc = iss_hit && iss_rd == ADDR_W'(r);
    assign dec = {1'b0, wb_hit && wb_rd == ADDR_W'(r)} + {1'b0, kill_hit && kill_rd == ADDR_W'(r)};
    assign sum = {1'b0, cnt[r]} + (CNT_W+1)'(inc);
    assign under[r] = (CNT_W+1)'(dec) > sum;
    always_ff @(posedge clk)
      cnt[r] <= !rst_n || under[r] ? '0 : CNT_W'(sum - (CNT_W+1)'(dec));
  end
  assign t_dec = {1'b0, wb_hit} + {1'b0, kill_hit};
  assign t_sum = {1'b0, inflight} + (TOT_W+1)'(iss_hit);
  assign t_under = (TOT_W+1)'(t_dec) > t_sum;
  assign t_next = t_sum - (TOT_W+1)'(t_dec);
  always_ff @(posedge clk) begin
    inflight <= !rst_n || t_under ? '0 : t_next[TOT_W-1:0];
    sb_err <= !rst_n ? 1'b0 : sb_err || t_under || t_next[TOT_W] || |under;
  end
endmodule
